fp_result_pack: RTL
===================

FP_RESULT_PACK -- requirements
Module: fp_result_pack

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  multiplier result present.
REQ-005 SHALL have port in_ready  output  1  block can accept a result.
REQ-006 SHALL have port in_sign  input  1  product sign (sign_a XOR sign_b).
REQ-007 SHALL have port in_class  input  2  operand class: 00 normal, 01 zero, 10 inf, 11 NaN/invalid.
REQ-008 SHALL have port in_mantissa  input  23  normalised, rounded fraction from the multiplier.
REQ-009 SHALL have port in_exp  input  8  biased exponent from the multiplier.
REQ-010 SHALL have port in_overflow  input  1  multiplier exponent overflow.
REQ-011 SHALL have port out_valid  output  1  packed result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_result  output  32  IEEE-754 single word.
REQ-014 SHALL have port out_flags  output  3  per-result flags {invalid, overflow, underflow}.

Function
REQ-015 SHALL accept an input on a clk edge where in_valid && in_ready (push).
REQ-016 SHALL drive in_ready = (count < DEPTH); in_ready SHALL NOT depend on out_ready.
REQ-017 SHALL pack with priority: class 11 -> 32'h7FC00000 (sign ignored), invalid=1.
REQ-018 SHALL pack class 10 -> {sign, 8'hFF, 23'h0}, no flags.
REQ-019 SHALL pack class 01 -> {sign, 31'h0}, no flags.
REQ-020 SHALL pack class 00 with in_overflow=1 -> {sign, 8'hFF, 23'h0}, overflow=1.
REQ-021 SHALL pack class 00 with in_exp==0 -> {sign, 31'h0} (flush-to-zero), underflow=1.
REQ-022 SHALL otherwise pack {sign, in_exp, in_mantissa}, no flags.
REQ-023 SHALL store packed result and flags in a DEPTH-entry FIFO; latency push-to-out_valid is exactly 1 cycle when empty.
REQ-024 SHALL pop on a clk edge where out_valid && out_ready; out_result/out_flags SHALL hold stable while out_valid && !out_ready.
REQ-025 SHALL allow simultaneous push and pop when count>0 and count<DEPTH: count unchanged, order preserved.
REQ-026 SHALL, when full with out_ready=1, pop only that cycle (in_ready=0); push resumes next cycle.
REQ-027 SHALL wrap read/write pointers modulo DEPTH without losing entries.
REQ-028 SHALL drive out_valid = (count > 0); out_result/out_flags SHALL be 0 when empty.

Reset
REQ-029 SHALL on rst asynchronously clear count, pointers, out_valid=0, out_result=0, out_flags=0, in_ready=1 after release.
REQ-030 SHALL discard all buffered results on rst asserted mid-operation; no partial entry emerges after release.

Configuration
REQ-031 SHALL, with FP_PACK_STICKY_FLAGS_EN defined, add ports flags_clr input 1 and sticky_flags output 3.
REQ-032 SHALL with the macro OR each popped entry's flags into sticky_flags; flags_clr clears it; simultaneous clear and pop yields that pop's flags only; reset value 0.
REQ-033 SHALL without the macro omit flags_clr, sticky_flags and their register; all other behaviour identical.

Structure
REQ-034 SHALL take from shared package fp_pkg: class encoding constants, flag bit indices, QNAN (32'h7FC00000), EXP_INF (8'hFF).
REQ-035 SHALL implement buffering in one sub-module fp_result_fifo (DEPTH, width 35); packing logic stays in fp_result_pack.

Verification
REQ-036 SHALL cover: normal push sign=1,exp=8'h80,mant=23'h400000 -> next cycle out_result=32'hC0400000, flags=000.
REQ-037 SHALL cover: class 00,in_overflow=1,sign=0 -> 32'h7F800000, flags=010; class 00,exp=0 -> 32'h00000000, flags=001.
REQ-038 SHALL cover: class 11,sign=1 -> 32'h7FC00000, flags=100; class 10,sign=1 -> 32'hFF800000.
REQ-039 SHALL cover: out_ready=0, push 3 results (DEPTH=2) -> in_ready=0 after 2; release -> results in order, third accepted on first pop+1.
REQ-040 SHALL cover: rst asserted with 2 entries buffered -> out_valid=0, out_result=0 same cycle; with FP_PACK_STICKY_FLAGS_EN, overflow then NaN popped -> sticky_flags=110, flags_clr -> 000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point encodings for the multiplier result path: operand
// classes, flag bit positions and the special IEEE-754 single-precision codes.
package fp_pkg;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  // Flag vector layout is {invalid, overflow, underflow}.
  localparam int FLAG_UNDERFLOW = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_INVALID   = 2;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  // One buffered entry is {flags[2:0], result[31:0]}.
  localparam int ENTRY_W = 35;

endpackage

// File: rtl/fp_result_fifo.sv
// Circular result buffer with combinational read port; reads as zero when empty.
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             can_push,
  output logic             has_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign can_push = (count < DEPTH_C);
  assign has_data = (count != '0);
  assign do_push  = push && can_push;
  assign do_pop   = pop && has_data;
  assign rd_data  = has_data ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale words are never visible while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_result_pack.sv
// Packs multiplier results into IEEE-754 single words with exception flags and
// buffers them. Define FP_PACK_STICKY_FLAGS_EN to add accumulated sticky flags.
module fp_result_pack
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [1:0]  in_class,
  input  logic [22:0] in_mantissa,
  input  logic [7:0]  in_exp,
  input  logic        in_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
`ifdef FP_PACK_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [2:0]  sticky_flags
`endif
);

  logic [31:0]        pk_result;
  logic [2:0]         pk_flags;
  logic [ENTRY_W-1:0] rd_entry;
  logic               pop;

  // Class decode takes precedence over the overflow/underflow indications.
  always_comb begin
    pk_result = {in_sign, in_exp, in_mantissa};
    pk_flags  = '0;
    case (in_class)
      CLS_NAN: begin
        pk_result              = QNAN;
        pk_flags[FLAG_INVALID] = 1'b1;
      end
      CLS_INF:  pk_result = {in_sign, EXP_INF, 23'h0};
      CLS_ZERO: pk_result = {in_sign, 31'h0};
      default: begin
        if (in_overflow) begin
          pk_result               = {in_sign, EXP_INF, 23'h0};
          pk_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (in_exp == 8'h00) begin
          pk_result                = {in_sign, 31'h0};
          pk_flags[FLAG_UNDERFLOW] = 1'b1;
        end
      end
    endcase
  end

  assign pop = out_valid && out_ready;

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .wr_data  ({pk_flags, pk_result}),
    .pop      (pop),
    .rd_data  (rd_entry),
    .can_push (in_ready),
    .has_data (out_valid)
  );

  assign out_flags  = rd_entry[34:32];
  assign out_result = rd_entry[31:0];

`ifdef FP_PACK_STICKY_FLAGS_EN
  // A clear coinciding with a pop keeps only the flags of that pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (flags_clr) begin
      sticky_flags <= pop ? out_flags : 3'b000;
    end else if (pop) begin
      sticky_flags <= sticky_flags | out_flags;
    end
  end
`endif

endmodule
